ram_arbiter2: RTL and testbench

Two-requester scheduler for the single-port 128x32 synchronous RAM in this design. It grants the RAM to requester A or B each cycle, with round-robin fairness bounded by a burst limit. It drives the RAM write-enable, address and write data, and returns read data to the requester that issued the read. It sits between two client engines and one RAM instance, and adds no latency beyond the RAM's own one-cycle read.

---
 rtl/ram_arbiter2_if.sv | 36 +++
 rtl/ram_arbiter2.sv | 100 ++++++++++
 tb/tb_ram_arbiter2.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter2_if.sv
// rtl/ram_arbiter2_if.sv - requester A/B and RAM signal bundle for ram_arbiter2
interface ram_arbiter2_if #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7
);
  logic                  a_req;
  logic                  b_req;
  logic                  a_we;
  logic                  b_we;
  logic [Addr_width-1:0] a_addr;
  logic [Addr_width-1:0] b_addr;
  logic [Data_width-1:0] a_wdata;
  logic [Data_width-1:0] b_wdata;
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  a_rvalid;
  logic                  b_rvalid;
  logic [Data_width-1:0] a_rdata;
  logic [Data_width-1:0] b_rdata;
  logic                  ram_we;
  logic [Addr_width-1:0] ram_address;
  logic [Data_width-1:0] ram_d;
  logic [Data_width-1:0] ram_q;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_q,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output ram_we, ram_address, ram_d
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_q,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  ram_we, ram_address, ram_d
  );
endinterface

// File: rtl/ram_arbiter2.sv
// rtl/ram_arbiter2.sv - round-robin, burst-limited two-requester scheduler for a single-port RAM
module ram_arbiter2 #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7,
  parameter int MAX_BURST  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_arbiter2_if.slave  bus
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  owner_t                r_last_owner;
  owner_t                w_last_owner_nxt;
  logic [3:0]            r_burst_cnt;
  logic [3:0]            w_burst_cnt_nxt;
  logic                  r_rd_pend_a;
  logic                  r_rd_pend_b;
  logic [Data_width-1:0] r_a_rdata;
  logic [Data_width-1:0] r_b_rdata;
  logic                  w_win_a;
  logic                  w_win_b;
  logic                  w_keep_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_B;
      r_burst_cnt  <= '0;
      r_rd_pend_a  <= 1'b0;
      r_rd_pend_b  <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_rd_pend_a  <= w_win_a & ~bus.a_we;
      r_rd_pend_b  <= w_win_b & ~bus.b_we;
      if (r_rd_pend_a) r_a_rdata <= bus.ram_q;
      if (r_rd_pend_b) r_b_rdata <= bus.ram_q;
    end
  end

  always_comb begin
    w_win_a          = 1'b0;
    w_win_b          = 1'b0;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = '0;
    bus.a_gnt        = 1'b0;
    bus.b_gnt        = 1'b0;
    bus.ram_we       = 1'b0;
    bus.ram_address  = bus.a_addr;
    bus.ram_d        = '0;
    // A zero count means no burst is running, so contention goes to the other side.
    w_keep_owner     = (r_burst_cnt != 4'd0) && (r_burst_cnt < MaxBurst);

    if (rst_n) begin
      if (bus.a_req && bus.b_req) begin
        w_win_a = w_keep_owner ? (r_last_owner == OWN_A) : (r_last_owner == OWN_B);
        w_win_b = ~w_win_a;
      end else begin
        w_win_a = bus.a_req;
        w_win_b = bus.b_req;
      end
    end

    if (w_win_a) begin
      bus.a_gnt       = 1'b1;
      bus.ram_we      = bus.a_we;
      bus.ram_address = bus.a_addr;
      bus.ram_d       = bus.a_wdata;
    end else if (w_win_b) begin
      bus.b_gnt       = 1'b1;
      bus.ram_we      = bus.b_we;
      bus.ram_address = bus.b_addr;
      bus.ram_d       = bus.b_wdata;
    end

    if (w_win_a || w_win_b) begin
      if ((w_win_a && r_last_owner == OWN_A) || (w_win_b && r_last_owner == OWN_B)) begin
        w_burst_cnt_nxt = (r_burst_cnt >= MaxBurst) ? MaxBurst : r_burst_cnt + 4'd1;
      end else begin
        w_last_owner_nxt = w_win_a ? OWN_A : OWN_B;
        w_burst_cnt_nxt  = 4'd1;
      end
    end
  end

  // The RAM already registers q, so the pending cycle passes it straight through.
  assign bus.a_rvalid = r_rd_pend_a;
  assign bus.b_rvalid = r_rd_pend_b;
  assign bus.a_rdata  = r_rd_pend_a ? bus.ram_q : r_a_rdata;
  assign bus.b_rdata  = r_rd_pend_b ? bus.ram_q : r_b_rdata;

endmodule

// File: tb/tb_ram_arbiter2.sv
// tb/tb_ram_arbiter2.sv - directed self-checking bench for ram_arbiter2
module tb_ram_arbiter2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] mem [0:127];

  ram_arbiter2_if #(.Data_width(32), .Addr_width(7)) bus ();

  ram_arbiter2 #(.Data_width(32), .Addr_width(7), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes update memory, reads register q
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_address] <= bus.ram_d;
    else            bus.ram_q <= mem[bus.ram_address];
  end

  task automatic idle_cycles(input int n);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.b_req = 1'b1; bus.b_we = 1'b0;
    #1;
    checks++; if (bus.a_gnt !== 1'b0) begin errors++; $display("FAIL rst a_gnt got %b exp 0", bus.a_gnt); end
    checks++; if (bus.b_gnt !== 1'b0) begin errors++; $display("FAIL rst b_gnt got %b exp 0", bus.b_gnt); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst ram_we got %b exp 0", bus.ram_we); end
    checks++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rst rvalid got %b%b exp 00", bus.a_rvalid, bus.b_rvalid); end
    checks++; if (bus.a_rdata !== 32'h0 || bus.b_rdata !== 32'h0) begin errors++; $display("FAIL rst rdata got %h %h exp 0 0", bus.a_rdata, bus.b_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_single_write_read;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 7'd5; bus.a_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL wr a_gnt got %b exp 1", bus.a_gnt); end
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_address !== 7'd5 || bus.ram_d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr ram got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", bus.ram_we, bus.ram_address, bus.ram_d); end
    @(negedge clk);
    bus.a_we = 1'b0;
    #1;
    checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rd a_gnt got %b exp 1", bus.a_gnt); end
    checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL wr a_rvalid got %b exp 0", bus.a_rvalid); end
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    checks++; if (bus.a_rvalid !== 1'b1) begin errors++; $display("FAIL rd a_rvalid got %b exp 1", bus.a_rvalid); end
    checks++; if (bus.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd a_rdata got %h exp deadbeef", bus.a_rdata); end
    checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd b_rvalid got %b exp 0", bus.b_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold a got v=%b d=%h exp v=0 d=deadbeef", bus.a_rvalid, bus.a_rdata); end
    idle_cycles(1);
  endtask

  task automatic test_contention;
    logic exp_a;
    logic prev_a;
    prev_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'd1;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd2;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_a = (i < 4) || (i == 8);
      checks++; if (bus.a_gnt !== exp_a) begin errors++; $display("FAIL cont a_gnt[%0d] got %b exp %b", i, bus.a_gnt, exp_a); end
      checks++; if (bus.b_gnt !== ~exp_a) begin errors++; $display("FAIL cont b_gnt[%0d] got %b exp %b", i, bus.b_gnt, ~exp_a); end
      if (i > 0) begin
        checks++; if (bus.a_rvalid !== prev_a || bus.b_rvalid !== ~prev_a) begin errors++; $display("FAIL cont rvalid[%0d] got %b%b exp %b%b", i, bus.a_rvalid, bus.b_rvalid, prev_a, ~prev_a); end
        checks++; if (prev_a ? (bus.a_rdata !== 32'hA0000001) : (bus.b_rdata !== 32'hA0000002)) begin errors++; $display("FAIL cont rdata[%0d] got a=%h b=%h exp %s", i, bus.a_rdata, bus.b_rdata, prev_a ? "a=a0000001" : "b=a0000002"); end
      end
      prev_a = exp_a;
    end
    @(negedge clk);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    #1;
    checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hA0000001) begin errors++; $display("FAIL cont last got v=%b d=%h exp v=1 d=a0000001", bus.a_rvalid, bus.a_rdata); end
    idle_cycles(2);
  endtask

  task automatic test_burst_yield;
    logic exp_a;
    bus.a_we = 1'b0; bus.a_addr = 7'd4;
    bus.b_we = 1'b0; bus.b_addr = 7'd3;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.b_req = 1'b1;
      bus.a_req = (i == 10);
      #1;
      exp_a = (i == 10);
      checks++; if (bus.a_gnt !== exp_a || bus.b_gnt !== ~exp_a) begin errors++; $display("FAIL yield10[%0d] got a=%b b=%b exp a=%b", i, bus.a_gnt, bus.b_gnt, exp_a); end
    end
    idle_cycles(2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.b_req = 1'b1;
      bus.a_req = (i >= 2);
      #1;
      exp_a = (i >= 4);
      checks++; if (bus.a_gnt !== exp_a || bus.b_gnt !== ~exp_a) begin errors++; $display("FAIL yield2[%0d] got a=%b b=%b exp a=%b", i, bus.a_gnt, bus.b_gnt, exp_a); end
    end
    idle_cycles(2);
  endtask

  task automatic test_idle_write;
    bus.a_addr = 7'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin errors++; $display("FAIL idle gnt[%0d] got %b%b exp 00", i, bus.a_gnt, bus.b_gnt); end
      checks++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL idle rvalid[%0d] got %b%b exp 00", i, bus.a_rvalid, bus.b_rvalid); end
      checks++; if (bus.ram_we !== 1'b0 || bus.ram_address !== 7'd7 || bus.ram_d !== 32'h0) begin errors++; $display("FAIL idle ram[%0d] got we=%b a=%0d d=%h exp we=0 a=7 d=0", i, bus.ram_we, bus.ram_address, bus.ram_d); end
    end
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 7'd127; bus.b_wdata = 32'h1;
    #1;
    checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin errors++; $display("FAIL bwr gnt got a=%b b=%b exp a=0 b=1", bus.a_gnt, bus.b_gnt); end
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_address !== 7'd127 || bus.ram_d !== 32'h1) begin errors++; $display("FAIL bwr ram got we=%b a=%0d d=%h exp we=1 a=127 d=1", bus.ram_we, bus.ram_address, bus.ram_d); end
    @(negedge clk);
    bus.b_req = 1'b0;
    #1;
    checks++; if (bus.b_rvalid !== 1'b0 || bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL bwr rvalid got %b%b exp 00", bus.a_rvalid, bus.b_rvalid); end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'd5;
    #1;
    checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL mid a_gnt got %b exp 1", bus.a_gnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.a_req = 1'b0;
    #1;
    checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL mid a_rvalid got %b exp 0", bus.a_rvalid); end
    checks++; if (bus.a_rdata !== 32'h0) begin errors++; $display("FAIL mid a_rdata got %h exp 0", bus.a_rdata); end
    @(negedge clk);
    #1;
    checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL mid replay a_rvalid got %b exp 0", bus.a_rvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_addr = 7'd1;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd2;
    #1;
    checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin errors++; $display("FAIL mid first got a=%b b=%b exp a=1 b=0", bus.a_gnt, bus.b_gnt); end
    idle_cycles(3);
  endtask

  task automatic test_interleaved;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 7'd8; bus.b_wdata = 32'h77;
    #1;
    checks++; if (bus.b_gnt !== 1'b1) begin errors++; $display("FAIL il b_gnt0 got %b exp 1", bus.b_gnt); end
    @(negedge clk);
    bus.b_addr = 7'd9; bus.b_wdata = 32'h55;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'd9;
    #1;
    checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin errors++; $display("FAIL il contend got a=%b b=%b exp a=0 b=1", bus.a_gnt, bus.b_gnt); end
    checks++; if (bus.ram_d !== 32'h55 || bus.ram_address !== 7'd9) begin errors++; $display("FAIL il ram got a=%0d d=%h exp a=9 d=55", bus.ram_address, bus.ram_d); end
    @(negedge clk);
    bus.b_req = 1'b0;
    #1;
    checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL il a_gnt got %b exp 1", bus.a_gnt); end
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    checks++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'h55) begin errors++; $display("FAIL il a_rdata got v=%b d=%h exp v=1 d=55", bus.a_rvalid, bus.a_rdata); end
    idle_cycles(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] <= 32'hA0000000 | 32'(i);
    repeat (2) @(negedge clk);
    test_reset;
    test_single_write_read;
    test_contention;
    test_burst_yield;
    test_idle_write;
    test_reset_mid_read;
    test_interleaved;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
